// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_pkg
// Purpose  : Shared encodings for the execute stage: ALUOp, funct codes,
//            forwarding selects, mult/div op and FSM state types.
// Revision : 1.0
// ============================================================================
package ex_pkg;

  localparam int c_DEF_DATA_WIDTH     = 32;
  localparam int c_DEF_REG_ADDR_WIDTH = 5;

  // ALUOp encodings from the main decoder
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] c_ALUOP_ORI   = 2'b11;

  // Forwarding mux selects (2'b11 is reserved and behaves like ID/EX)
  localparam logic [1:0] c_FWD_IDEX  = 2'b00;
  localparam logic [1:0] c_FWD_EXMEM = 2'b01;
  localparam logic [1:0] c_FWD_MEMWB = 2'b10;

  // R-type funct codes
  localparam logic [5:0] c_FN_SLL   = 6'h00;
  localparam logic [5:0] c_FN_SRL   = 6'h02;
  localparam logic [5:0] c_FN_SRA   = 6'h03;
  localparam logic [5:0] c_FN_MFHI  = 6'h10;
  localparam logic [5:0] c_FN_MFLO  = 6'h12;
  localparam logic [5:0] c_FN_MULT  = 6'h18;
  localparam logic [5:0] c_FN_MULTU = 6'h19;
  localparam logic [5:0] c_FN_DIV   = 6'h1A;
  localparam logic [5:0] c_FN_DIVU  = 6'h1B;
  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_ADDU  = 6'h21;
  localparam logic [5:0] c_FN_SUB   = 6'h22;
  localparam logic [5:0] c_FN_SUBU  = 6'h23;
  localparam logic [5:0] c_FN_AND   = 6'h24;
  localparam logic [5:0] c_FN_OR    = 6'h25;
  localparam logic [5:0] c_FN_XOR   = 6'h26;
  localparam logic [5:0] c_FN_NOR   = 6'h27;
  localparam logic [5:0] c_FN_SLT   = 6'h2A;
  localparam logic [5:0] c_FN_SLTU  = 6'h2B;

  // Mult/div op: matches funct[1:0] of 18..1B
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative shift-add multiplier / restoring divider with HI/LO.
//            One step per falling clock edge, DATA_WIDTH steps per op.
// Revision : 1.0
// ============================================================================
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_WIDTH - 1);

  md_state_e               r_state;
  md_state_e               w_state_nx;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_acc;    // product high half / partial remainder
  logic [DATA_WIDTH-1:0]   r_q;      // multiplier bits / quotient bits
  logic [DATA_WIDTH-1:0]   r_opnd;   // multiplicand / divisor magnitude
  logic                    r_is_div;
  logic                    r_neg_q;  // negate product or quotient at the end
  logic                    r_neg_r;  // negate remainder at the end
  logic                    r_div0;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;

  md_op_e                  w_op;
  logic                    w_signed;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_a_mag;
  logic [DATA_WIDTH-1:0]   w_b_mag;
  logic                    w_last;
  logic [DATA_WIDTH:0]     w_mul_sum;
  logic [DATA_WIDTH:0]     w_div_sh;
  logic [DATA_WIDTH-1:0]   w_div_sub;
  logic                    w_div_ge;
  logic [DATA_WIDTH-1:0]   w_acc_nx;
  logic [DATA_WIDTH-1:0]   w_q_nx;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [2*DATA_WIDTH-1:0] w_prod_fix;
  logic [DATA_WIDTH-1:0]   w_quo_fix;
  logic [DATA_WIDTH-1:0]   w_rem_fix;

  assign w_op     = md_op_e'(i_op);
  assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_a_neg  = w_signed && i_a[DATA_WIDTH-1];
  assign w_b_neg  = w_signed && i_b[DATA_WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_b_mag  = w_b_neg ? (~i_b + 1'b1) : i_b;
  assign w_last   = (r_cnt == c_LAST);
  assign o_busy   = (r_state == MD_RUN);
  assign o_hi     = r_hi;
  assign o_lo     = r_lo;

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : '0);
    w_div_sh  = {r_acc, r_q[DATA_WIDTH-1]};
    w_div_ge  = (w_div_sh >= {1'b0, r_opnd});
    // True difference is below the divisor, so DATA_WIDTH bits suffice
    w_div_sub = w_div_sh[DATA_WIDTH-1:0] - r_opnd;
    if (r_is_div) begin
      w_acc_nx = w_div_ge ? w_div_sub : w_div_sh[DATA_WIDTH-1:0];
      w_q_nx   = {r_q[DATA_WIDTH-2:0], w_div_ge};
    end else begin
      w_acc_nx = w_mul_sum[DATA_WIDTH:1];
      w_q_nx   = {w_mul_sum[0], r_q[DATA_WIDTH-1:1]};
    end
  end

  // Sign fixup applied to the final step's result; a zero divisor forces
  // an all-ones quotient while the remainder naturally returns the dividend
  always_comb begin
    w_prod     = {w_acc_nx, w_q_nx};
    w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    w_quo_fix  = r_div0 ? '1 : (r_neg_q ? (~w_q_nx + 1'b1) : w_q_nx);
    w_rem_fix  = r_neg_r ? (~w_acc_nx + 1'b1) : w_acc_nx;
  end

  // FSM next state: IDLE -> RUN on start, RUN -> IDLE after the last step
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      MD_IDLE: if (i_start) w_state_nx = MD_RUN;
      MD_RUN:  if (w_last)  w_state_nx = MD_IDLE;
      default: w_state_nx = MD_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(negedge clock) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_state_nx;
  end

  // Operand latch, iteration datapath and HI/LO update
  always_ff @(negedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (r_state == MD_IDLE) begin
      if (i_start) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_is_div <= (w_op == MD_DIV) || (w_op == MD_DIVU);
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_div0   <= (i_b == '0);
        if ((w_op == MD_DIV) || (w_op == MD_DIVU)) begin
          r_q    <= w_a_mag;
          r_opnd <= w_b_mag;
        end else begin
          r_q    <= w_b_mag;
          r_opnd <= w_a_mag;
        end
      end
    end else begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      r_cnt <= w_last ? '0 : (r_cnt + 1'b1);
      if (w_last) begin
        if (r_is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end else begin
          r_hi <= w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
          r_lo <= w_prod_fix[DATA_WIDTH-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : MIPS execute stage: forwarding muxes, ALU, mult/div issue,
//            HI/LO hazard stall and the EX/MEM pipeline register.
// Revision : 1.0
// ============================================================================
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = c_DEF_REG_ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     data_a_in,
  input  logic [DATA_WIDTH-1:0]     data_b_in,
  input  logic [DATA_WIDTH-1:0]     sign_extend_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_dest_r_type_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_dest_l_type_in,
  input  logic                      RegDst_in,
  input  logic                      ALUSrc_in,
  input  logic                      MemToReg_in,
  input  logic                      RegWrite_in,
  input  logic                      MemRead_in,
  input  logic                      MemWrite_in,
  input  logic                      Branch_in,
  input  logic [1:0]                ALUOp_in,
  input  logic [1:0]                fwd_a_sel,
  input  logic [1:0]                fwd_b_sel,
  input  logic [DATA_WIDTH-1:0]     ex_mem_fwd_in,
  input  logic [DATA_WIDTH-1:0]     mem_wb_fwd_in,
  input  logic                      flush,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [DATA_WIDTH-1:0]     write_data_out,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_out,
  output logic                      zero_out,
  output logic                      MemToReg_out,
  output logic                      RegWrite_out,
  output logic                      MemRead_out,
  output logic                      MemWrite_out,
  output logic                      Branch_out,
  output logic                      stall_out,
  output logic                      md_busy_out
);

  logic [5:0]            w_funct;
  logic [4:0]            w_shamt;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_fwd_b;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic [DATA_WIDTH-1:0] w_imm_zx;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_wr_ok;
  logic                  w_is_md;
  logic                  w_is_hilo;
  logic                  w_md_start;
  logic                  w_bubble;
  logic                  w_md_busy;
  logic [DATA_WIDTH-1:0] w_hi;
  logic [DATA_WIDTH-1:0] w_lo;

  assign w_funct  = sign_extend_in[5:0];
  assign w_shamt  = sign_extend_in[10:6];
  assign w_imm_zx = {{(DATA_WIDTH-16){1'b0}}, sign_extend_in[15:0]};
  assign w_op_b   = ALUSrc_in ? sign_extend_in : w_fwd_b;

  // Forwarding muxes for rs and rt
  always_comb begin
    case (fwd_a_sel)
      c_FWD_EXMEM: w_op_a = ex_mem_fwd_in;
      c_FWD_MEMWB: w_op_a = mem_wb_fwd_in;
      default:     w_op_a = data_a_in;
    endcase
    case (fwd_b_sel)
      c_FWD_EXMEM: w_fwd_b = ex_mem_fwd_in;
      c_FWD_MEMWB: w_fwd_b = mem_wb_fwd_in;
      default:     w_fwd_b = data_b_in;
    endcase
  end

  // ALU and funct decode; also flags HI/LO readers and mult/div issue
  always_comb begin
    w_result  = '0;
    w_wr_ok   = 1'b1;
    w_is_md   = 1'b0;
    w_is_hilo = 1'b0;
    case (ALUOp_in)
      c_ALUOP_ADD: w_result = w_op_a + w_op_b;
      c_ALUOP_SUB: w_result = w_op_a - w_op_b;
      c_ALUOP_ORI: w_result = w_op_a | w_imm_zx;
      default: begin
        case (w_funct)
          c_FN_ADD, c_FN_ADDU: w_result = w_op_a + w_op_b;
          c_FN_SUB, c_FN_SUBU: w_result = w_op_a - w_op_b;
          c_FN_AND:  w_result = w_op_a & w_op_b;
          c_FN_OR:   w_result = w_op_a | w_op_b;
          c_FN_XOR:  w_result = w_op_a ^ w_op_b;
          c_FN_NOR:  w_result = ~(w_op_a | w_op_b);
          c_FN_SLT:  w_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
          c_FN_SLTU: w_result = {{(DATA_WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
          c_FN_SLL:  w_result = w_op_b << w_shamt;
          c_FN_SRL:  w_result = w_op_b >> w_shamt;
          c_FN_SRA:  w_result = $signed(w_op_b) >>> w_shamt;
          c_FN_MFHI: begin w_result = w_hi; w_is_hilo = 1'b1; end
          c_FN_MFLO: begin w_result = w_lo; w_is_hilo = 1'b1; end
          c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU: begin
            w_is_md = 1'b1;
            w_wr_ok = 1'b0;
          end
          default:   w_wr_ok = 1'b0;
        endcase
      end
    endcase
  end

  // A flush always wins over a stall, so a flushed instruction never waits
  assign stall_out   = w_md_busy && (w_is_md || w_is_hilo) && !flush;
  assign w_bubble    = stall_out || flush;
  assign w_md_start  = w_is_md && !stall_out && !flush && !reset;
  assign md_busy_out = w_md_busy;

  muldiv_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clock   (clock),
    .reset   (reset),
    .i_start (w_md_start),
    .i_op    (w_funct[1:0]),
    .i_a     (w_op_a),
    .i_b     (w_fwd_b),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_busy  (w_md_busy)
  );

  // EX/MEM pipeline register; stalls and flushes insert an all-zero bubble
  always_ff @(negedge clock) begin
    if (reset || w_bubble) begin
      alu_result_out <= '0;
      write_data_out <= '0;
      write_reg_out  <= '0;
      zero_out       <= 1'b0;
      MemToReg_out   <= 1'b0;
      RegWrite_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      MemWrite_out   <= 1'b0;
      Branch_out     <= 1'b0;
    end else begin
      alu_result_out <= w_result;
      write_data_out <= w_fwd_b;
      write_reg_out  <= RegDst_in ? reg_dest_r_type_in : reg_dest_l_type_in;
      zero_out       <= (w_result == '0);
      MemToReg_out   <= MemToReg_in;
      RegWrite_out   <= RegWrite_in && w_wr_ok;
      MemRead_out    <= MemRead_in;
      MemWrite_out   <= MemWrite_in;
      Branch_out     <= Branch_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Directed self-checking bench for ex_stage (ALU, forwarding,
//            mult/div, HI/LO stall, flush and reset behaviour).
// Revision : 1.0
// ============================================================================
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_a_in, data_b_in, sign_extend_in;
  logic [4:0]  reg_dest_r_type_in, reg_dest_l_type_in;
  logic        RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in;
  logic        MemRead_in, MemWrite_in, Branch_in;
  logic [1:0]  ALUOp_in, fwd_a_sel, fwd_b_sel;
  logic [31:0] ex_mem_fwd_in, mem_wb_fwd_in;
  logic        flush;
  logic [31:0] alu_result_out, write_data_out;
  logic [4:0]  write_reg_out;
  logic        zero_out, MemToReg_out, RegWrite_out, MemRead_out;
  logic        MemWrite_out, Branch_out, stall_out, md_busy_out;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage dut (
    .clock              (clock),
    .reset              (reset),
    .data_a_in          (data_a_in),
    .data_b_in          (data_b_in),
    .sign_extend_in     (sign_extend_in),
    .reg_dest_r_type_in (reg_dest_r_type_in),
    .reg_dest_l_type_in (reg_dest_l_type_in),
    .RegDst_in          (RegDst_in),
    .ALUSrc_in          (ALUSrc_in),
    .MemToReg_in        (MemToReg_in),
    .RegWrite_in        (RegWrite_in),
    .MemRead_in         (MemRead_in),
    .MemWrite_in        (MemWrite_in),
    .Branch_in          (Branch_in),
    .ALUOp_in           (ALUOp_in),
    .fwd_a_sel          (fwd_a_sel),
    .fwd_b_sel          (fwd_b_sel),
    .ex_mem_fwd_in      (ex_mem_fwd_in),
    .mem_wb_fwd_in      (mem_wb_fwd_in),
    .flush              (flush),
    .alu_result_out     (alu_result_out),
    .write_data_out     (write_data_out),
    .write_reg_out      (write_reg_out),
    .zero_out           (zero_out),
    .MemToReg_out       (MemToReg_out),
    .RegWrite_out       (RegWrite_out),
    .MemRead_out        (MemRead_out),
    .MemWrite_out       (MemWrite_out),
    .Branch_out         (Branch_out),
    .stall_out          (stall_out),
    .md_busy_out        (md_busy_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Design updates on the falling edge; bench drives and samples on the rising edge
  task automatic tick();
    @(negedge clock);
    @(posedge clock);
  endtask

  task automatic clr();
    data_a_in = '0; data_b_in = '0; sign_extend_in = '0;
    reg_dest_r_type_in = 5'd9; reg_dest_l_type_in = 5'd4;
    RegDst_in = 0; ALUSrc_in = 0; MemToReg_in = 0; RegWrite_in = 0;
    MemRead_in = 0; MemWrite_in = 0; Branch_in = 0;
    ALUOp_in = 2'b00; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    ex_mem_fwd_in = '0; mem_wb_fwd_in = '0; flush = 0;
  endtask

  task automatic rtype(input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] funct, input logic [4:0] shamt);
    clr();
    ALUOp_in = 2'b10; RegDst_in = 1; RegWrite_in = 1;
    data_a_in = a; data_b_in = b;
    sign_extend_in = {21'd0, shamt, funct};
  endtask

  task automatic wait_idle();
    int k;
    clr();
    k = 0;
    while (md_busy_out === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("md_done_in_time", {31'd0, md_busy_out}, 32'd0);
  endtask

  // Issue one mult/div, run an independent add while busy, then read HI/LO
  task automatic md_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] funct, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    rtype(a, b, funct, 5'd0);
    tick();
    chk({tag, "_busy"}, {31'd0, md_busy_out}, 32'd1);
    rtype(32'd2, 32'd3, 6'h20, 5'd0);
    #1 chk({tag, "_add_nostall"}, {31'd0, stall_out}, 32'd0);
    tick();
    chk({tag, "_add_result"}, alu_result_out, 32'd5);
    wait_idle();
    rtype(0, 0, 6'h12, 5'd0);
    tick();
    chk({tag, "_lo"}, alu_result_out, exp_lo);
    rtype(0, 0, 6'h10, 5'd0);
    tick();
    chk({tag, "_hi"}, alu_result_out, exp_hi);
  endtask

  initial begin
    int n;
    clr();
    reset = 1;
    // Reset has priority over a valid instruction in EX
    rtype(32'd1, 32'd2, 6'h20, 5'd0);
    tick();
    chk("rst_alu", alu_result_out, 32'd0);
    chk("rst_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("rst_wreg", {27'd0, write_reg_out}, 32'd0);
    chk("rst_zero", {31'd0, zero_out}, 32'd0);
    chk("rst_busy", {31'd0, md_busy_out}, 32'd0);
    reset = 0;

    // add with rs forwarded from EX/MEM
    rtype(32'd0, 32'd7, 6'h20, 5'd0);
    fwd_a_sel = 2'b01; ex_mem_fwd_in = 32'd5;
    tick();
    chk("add_fwd_result", alu_result_out, 32'd12);
    chk("add_fwd_regwrite", {31'd0, RegWrite_out}, 32'd1);
    chk("add_fwd_wreg", {27'd0, write_reg_out}, 32'd9);
    chk("add_fwd_wdata", write_data_out, 32'd7);

    // sub with rt forwarded from MEM/WB
    rtype(32'd10, 32'd0, 6'h22, 5'd0);
    fwd_b_sel = 2'b10; mem_wb_fwd_in = 32'd3;
    tick();
    chk("sub_fwd_result", alu_result_out, 32'd7);
    chk("sub_fwd_wdata", write_data_out, 32'd3);

    rtype(32'd0, 32'h8000_0000, 6'h03, 5'd4); tick();
    chk("sra", alu_result_out, 32'hF800_0000);
    rtype(32'd0, 32'h8000_0000, 6'h02, 5'd4); tick();
    chk("srl", alu_result_out, 32'h0800_0000);
    rtype(32'd0, 32'h0000_0003, 6'h00, 5'd31); tick();
    chk("sll", alu_result_out, 32'h8000_0000);
    rtype(32'hFFFF_FFFF, 32'd1, 6'h2A, 5'd0); tick();
    chk("slt", alu_result_out, 32'd1);
    rtype(32'hFFFF_FFFF, 32'd1, 6'h2B, 5'd0); tick();
    chk("sltu", alu_result_out, 32'd0);
    chk("sltu_zero", {31'd0, zero_out}, 32'd1);
    rtype(32'h0F0F_0000, 32'h00FF_00FF, 6'h27, 5'd0); tick();
    chk("nor", alu_result_out, 32'hF000_FF00);
    rtype(32'hFFFF_FFFF, 32'd1, 6'h21, 5'd0); tick();
    chk("addu_wrap", alu_result_out, 32'd0);
    chk("addu_wrap_zero", {31'd0, zero_out}, 32'd1);
    rtype(32'd5, 32'd6, 6'h3F, 5'd0); tick();
    chk("unknown_result", alu_result_out, 32'd0);
    chk("unknown_regwrite", {31'd0, RegWrite_out}, 32'd0);

    // load-style add with immediate; destination is rt
    clr();
    ALUSrc_in = 1; MemRead_in = 1; MemToReg_in = 1; RegWrite_in = 1;
    data_a_in = 32'h100; sign_extend_in = 32'd8;
    tick();
    chk("lw_addr", alu_result_out, 32'h108);
    chk("lw_wreg", {27'd0, write_reg_out}, 32'd4);
    chk("lw_ctrl", {28'd0, MemRead_out, MemToReg_out, MemWrite_out, Branch_out}, 32'b1100);

    // store: negative offset, store data is rt
    clr();
    ALUSrc_in = 1; MemWrite_in = 1;
    data_a_in = 32'h200; data_b_in = 32'hDEAD_BEEF; sign_extend_in = 32'hFFFF_FFFC;
    tick();
    chk("sw_addr", alu_result_out, 32'h1FC);
    chk("sw_data", write_data_out, 32'hDEAD_BEEF);
    chk("sw_ctrl", {28'd0, MemRead_out, MemToReg_out, MemWrite_out, Branch_out}, 32'b0010);

    // beq-style subtract
    clr();
    ALUOp_in = 2'b01; Branch_in = 1; data_a_in = 32'd5; data_b_in = 32'd5;
    tick();
    chk("beq_zero", {31'd0, zero_out}, 32'd1);
    chk("beq_branch", {31'd0, Branch_out}, 32'd1);

    // ori zero-extends the immediate
    clr();
    ALUOp_in = 2'b11; ALUSrc_in = 1; RegWrite_in = 1;
    data_a_in = 32'h0000_00F0; sign_extend_in = 32'hFFFF_000F;
    tick();
    chk("ori", alu_result_out, 32'h0000_00FF);

    // signed mult followed immediately by mflo: stall until completion
    rtype(32'hFFFF_FFFF, 32'd3, 6'h18, 5'd0);
    #1 chk("mult_issue_nostall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("mult_busy", {31'd0, md_busy_out}, 32'd1);
    chk("mult_regwrite", {31'd0, RegWrite_out}, 32'd0);
    rtype(0, 0, 6'h12, 5'd0);
    n = 0;
    while (md_busy_out === 1'b1 && n < 40) begin
      #1 chk("mflo_stall", {31'd0, stall_out}, 32'd1);
      tick();
      n++;
      chk("mflo_bubble", {31'd0, RegWrite_out}, 32'd0);
    end
    chk("mult_busy_edges", n, 32'd32);
    #1 chk("mflo_released", {31'd0, stall_out}, 32'd0);
    tick();
    chk("mult_lo", alu_result_out, 32'hFFFF_FFFD);
    chk("mflo_regwrite", {31'd0, RegWrite_out}, 32'd1);
    rtype(0, 0, 6'h10, 5'd0); tick();
    chk("mult_hi", alu_result_out, 32'hFFFF_FFFF);

    md_run("multu", 32'hFFFF_FFFF, 32'd3, 6'h19, 32'h0000_0002, 32'hFFFF_FFFD);
    md_run("div0", 32'd7, 32'd0, 6'h1A, 32'd7, 32'hFFFF_FFFF);
    md_run("divu", 32'hFFFF_FFF9, 32'd2, 6'h1B, 32'd1, 32'h7FFF_FFFC);
    md_run("div", 32'hFFFF_FFF9, 32'd2, 6'h1A, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // flush with a div in EX while busy: no stall, bubble, div never starts
    rtype(32'd2, 32'd3, 6'h19, 5'd0);
    tick();
    rtype(32'd100, 32'd7, 6'h1A, 5'd0);
    flush = 1;
    #1 chk("flush_nostall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("flush_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("flush_alu", alu_result_out, 32'd0);
    chk("flush_wreg", {27'd0, write_reg_out}, 32'd0);
    chk("flush_busy_kept", {31'd0, md_busy_out}, 32'd1);
    wait_idle();
    tick();
    chk("flush_no_restart", {31'd0, md_busy_out}, 32'd0);
    rtype(0, 0, 6'h12, 5'd0); tick();
    chk("flush_lo", alu_result_out, 32'd6);
    rtype(0, 0, 6'h10, 5'd0); tick();
    chk("flush_hi", alu_result_out, 32'd0);

    // flushed divu on an idle unit does not start
    rtype(32'd9, 32'd2, 6'h1B, 5'd0);
    flush = 1;
    tick();
    chk("flush_idle_nostart", {31'd0, md_busy_out}, 32'd0);

    md_run("div_negneg", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 6'h1A, 32'hFFFF_FFFE, 32'd2);

    // reset in the middle of a multiply
    rtype(32'd5, 32'd7, 6'h18, 5'd0);
    tick();
    clr();
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_busy", {31'd0, md_busy_out}, 32'd1);
    reset = 1;
    rtype(32'd1, 32'd1, 6'h20, 5'd0);
    tick();
    reset = 0;
    chk("midrst_busy", {31'd0, md_busy_out}, 32'd0);
    chk("midrst_alu", alu_result_out, 32'd0);
    chk("midrst_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("midrst_wdata", write_data_out, 32'd0);
    rtype(0, 0, 6'h12, 5'd0); tick();
    chk("midrst_lo", alu_result_out, 32'd0);
    rtype(0, 0, 6'h10, 5'd0); tick();
    chk("midrst_hi", alu_result_out, 32'd0);
    tick();
    chk("midrst_stays_idle", {31'd0, md_busy_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
